// File: rtl/rv_alu_pkg.sv
// Shared ALU encodings and the ID/EX payload layout.
package rv_alu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_CTL_W  = 3;

  // ALU function selects
  localparam logic [ALU_CTL_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_CTL_W-1:0] ALU_NOT  = 3'b010;
  localparam logic [ALU_CTL_W-1:0] ALU_SLL  = 3'b011;
  localparam logic [ALU_CTL_W-1:0] ALU_SRL  = 3'b100;
  localparam logic [ALU_CTL_W-1:0] ALU_AND  = 3'b101;
  localparam logic [ALU_CTL_W-1:0] ALU_OR   = 3'b110;
  localparam logic [ALU_CTL_W-1:0] ALU_SLTU = 3'b111;

  // Main-decoder ALU operation classes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NOT   = 2'b11;

  // RV32 funct3 values
  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SRL  = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  // Everything latched into EX; an all-zero value is a bubble
  typedef struct packed {
    logic                  valid;
    logic [ALU_CTL_W-1:0]  alu_control;
    logic                  illegal;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic                  use_imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
  } ex_reg_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational translation of alu_op/funct3/funct7b5 into the ALU select.
module alu_op_decoder
  import rv_alu_pkg::*;
(
  input  logic [1:0]           alu_op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 is_rtype,
  output logic [ALU_CTL_W-1:0] alu_control,
  output logic                 illegal
);

  // Decode table; unsupported funct3 values fall back to add and flag illegal
  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_NOT: alu_control = ALU_NOT;
      default: begin
        case (funct3)
          FUNCT3_ADD:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
          FUNCT3_SLL:  alu_control = ALU_SLL;
          FUNCT3_SRL:  alu_control = ALU_SRL;
          FUNCT3_AND:  alu_control = ALU_AND;
          FUNCT3_OR:   alu_control = ALU_OR;
          FUNCT3_SLTU: alu_control = ALU_SLTU;
          default:     illegal     = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with funct decode, operand forwarding and load-use detection.
module id_ex_operand_stage
  import rv_alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [1:0]            id_alu_op,
  input  logic [2:0]            id_funct3,
  input  logic                  id_funct7b5,
  input  logic                  id_is_rtype,
  input  logic                  id_use_imm,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_regwrite,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_regwrite,
  input  logic [XLEN-1:0]       memwb_wdata,
  output logic [XLEN-1:0]       ex_a,
  output logic [XLEN-1:0]       ex_b,
  output logic [ALU_CTL_W-1:0]  ex_alu_control,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_regwrite,
  output logic                  ex_memread,
  output logic                  ex_valid,
  output logic                  ex_illegal,
  output logic                  load_use_stall
);

  ex_reg_t              ex_q;
  ex_reg_t              ex_d;
  logic [ALU_CTL_W-1:0] dec_control;
  logic                 dec_illegal;
  logic                 fwd_a_exmem, fwd_a_memwb;
  logic                 fwd_b_exmem, fwd_b_memwb;
  logic [XLEN-1:0]      rs2_fwd;

  alu_op_decoder u_decoder (
    .alu_op      (id_alu_op),
    .funct3      (id_funct3),
    .funct7b5    (id_funct7b5),
    .is_rtype    (id_is_rtype),
    .alu_control (dec_control),
    .illegal     (dec_illegal)
  );

  // Assemble the next EX payload from the ID fields
  always_comb begin
    ex_d             = '0;
    ex_d.valid       = id_valid;
    ex_d.alu_control = dec_control;
    ex_d.illegal     = dec_illegal;
    ex_d.rd          = id_rd;
    ex_d.regwrite    = id_regwrite;
    ex_d.memread     = id_memread;
    ex_d.use_imm     = id_use_imm;
    ex_d.rs1         = id_rs1;
    ex_d.rs2         = id_rs2;
    ex_d.rs1_data    = id_rs1_data;
    ex_d.rs2_data    = id_rs2_data;
    ex_d.imm         = id_imm;
  end

  // Load in EX whose result the instruction in ID needs next cycle
  always_comb begin
    load_use_stall = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid &&
                     ((ex_q.rd == id_rs1) || ((ex_q.rd == id_rs2) && !id_use_imm));
  end

  // Pipeline register: flush beats stall, stall beats the load-use bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (!stall) begin
      if (load_use_stall) begin
        ex_q <= '0;
      end else begin
        ex_q <= ex_d;
      end
    end
  end

  // Forwarding mux; EX/MEM takes precedence and x0 is never forwarded
  always_comb begin
    fwd_a_exmem = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_q.rs1);
    fwd_a_memwb = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_q.rs1);
    fwd_b_exmem = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_q.rs2);
    fwd_b_memwb = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_q.rs2);

    if (fwd_a_exmem)      ex_a = exmem_result;
    else if (fwd_a_memwb) ex_a = memwb_wdata;
    else                  ex_a = ex_q.rs1_data;

    if (fwd_b_exmem)      rs2_fwd = exmem_result;
    else if (fwd_b_memwb) rs2_fwd = memwb_wdata;
    else                  rs2_fwd = ex_q.rs2_data;

    ex_b = ex_q.use_imm ? ex_q.imm : rs2_fwd;
  end

  // Registered control outputs
  always_comb begin
    ex_alu_control = ex_q.alu_control;
    ex_rd          = ex_q.rd;
    ex_regwrite    = ex_q.regwrite;
    ex_memread     = ex_q.memread;
    ex_valid       = ex_q.valid;
    ex_illegal     = ex_q.illegal;
  end

endmodule
